// File: rtl/cover_toggle_collector.sv
// Sticky toggle-coverage collector: accumulates per-point hit strobes into a live
// bitmap and, on request, streams the global indices of a frozen snapshot.
module cover_toggle_collector #(
    parameter int W           = 11,
    parameter int COVER_INDEX = 0,
    parameter int CW          = $clog2(W + 1)
) (
    input  logic          gbl_clk,
    input  logic          reset,
    input  logic [W-1:0]  valid,
    input  logic          clear,
    input  logic          dump_req,
    input  logic          dump_ready,
    output logic          dump_valid,
    output logic [63:0]   dump_index,
    output logic          dump_last,
    output logic          dump_done,
    output logic          dump_busy,
    output logic          new_hit,
    output logic [CW-1:0] hit_count
);

    localparam int PW = (W > 1) ? $clog2(W) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < W; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    logic [W-1:0]  bm_r;
    logic [CW-1:0] hit_count_r;
    logic          new_hit_r;
    logic [1:0]    state_r;
    logic [PW-1:0] ptr_r;
    logic [W-1:0]  snap_r;
    logic          dump_valid_r;
    logic [63:0]   dump_index_r;
    logic          dump_last_r;
    logic          dump_done_r;
    logic          dump_busy_r;

    logic [W-1:0]  fresh_s;
    logic [W-1:0]  bm_nxt_s;
    logic [CW-1:0] hit_count_nxt_s;
    logic          new_hit_nxt_s;
    logic [1:0]    state_nxt_s;
    logic [PW-1:0] ptr_nxt_s;
    logic [W-1:0]  snap_nxt_s;
    logic          advance_s;
    logic [W-1:0]  above_s;
    logic          valid_nxt_s;
    logic          last_nxt_s;
    logic [63:0]   index_nxt_s;

    // Live bitmap update; clear wins over accumulation and runs in every FSM state.
    always_comb begin
        fresh_s         = valid & ~bm_r;
        bm_nxt_s        = bm_r;
        hit_count_nxt_s = hit_count_r;
        new_hit_nxt_s   = 1'b0;
        if (clear) begin
            bm_nxt_s        = valid;
            hit_count_nxt_s = popcount(valid);
            new_hit_nxt_s   = |valid;
        end else begin
            bm_nxt_s        = bm_r | valid;
            hit_count_nxt_s = hit_count_r + popcount(fresh_s);
            new_hit_nxt_s   = |fresh_s;
        end
    end

    // Dump sequencer: zero bits cost one cycle, set bits wait for the consumer.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        snap_nxt_s  = snap_r;
        advance_s   = !snap_r[ptr_r] || dump_ready;
        case (state_r)
            IDLE: begin
                if (dump_req) begin
                    snap_nxt_s  = bm_r | valid;
                    ptr_nxt_s   = {PW{1'b0}};
                    state_nxt_s = SCAN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (advance_s) begin
                    if (ptr_r == LAST_PTR) begin
                        state_nxt_s = DONE;
                    end else begin
                        ptr_nxt_s = ptr_r + {{(PW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output values are derived from next state so every output leaves a flop.
    always_comb begin
        valid_nxt_s = (state_nxt_s == SCAN) && snap_nxt_s[ptr_nxt_s];
        above_s     = (snap_nxt_s >> ptr_nxt_s) >> 1'b1;
        last_nxt_s  = valid_nxt_s && (above_s == {W{1'b0}});
        if (valid_nxt_s) begin
            index_nxt_s = 64'(COVER_INDEX) + 64'(ptr_nxt_s);
        end else begin
            index_nxt_s = 64'd0;
        end
    end

    // Coverage state registers.
    always_ff @(posedge gbl_clk or posedge reset) begin
        if (reset) begin
            bm_r        <= {W{1'b0}};
            hit_count_r <= {CW{1'b0}};
            new_hit_r   <= 1'b0;
        end else begin
            bm_r        <= bm_nxt_s;
            hit_count_r <= hit_count_nxt_s;
            new_hit_r   <= new_hit_nxt_s;
        end
    end

    // Dump sequencer registers.
    always_ff @(posedge gbl_clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            ptr_r   <= {PW{1'b0}};
            snap_r  <= {W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            snap_r  <= snap_nxt_s;
        end
    end

    // Dump stream output registers.
    always_ff @(posedge gbl_clk or posedge reset) begin
        if (reset) begin
            dump_valid_r <= 1'b0;
            dump_index_r <= 64'd0;
            dump_last_r  <= 1'b0;
            dump_done_r  <= 1'b0;
            dump_busy_r  <= 1'b0;
        end else begin
            dump_valid_r <= valid_nxt_s;
            dump_index_r <= index_nxt_s;
            dump_last_r  <= last_nxt_s;
            dump_done_r  <= (state_nxt_s == DONE);
            dump_busy_r  <= (state_nxt_s != IDLE);
        end
    end

    assign dump_valid = dump_valid_r;
    assign dump_index = dump_index_r;
    assign dump_last  = dump_last_r;
    assign dump_done  = dump_done_r;
    assign dump_busy  = dump_busy_r;
    assign new_hit    = new_hit_r;
    assign hit_count  = hit_count_r;

endmodule

// File: doc/cover_toggle_collector.md
COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 Parameter W, default 11: width of the incoming cover-valid vector (W >= 1).
REQ-002 Parameter COVER_INDEX, default 0: global cover index of valid[0].
REQ-003 Parameter CW, default $clog2(W+1): width of hit_count.
REQ-004 clock  in  1  sole clock; all state on posedge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 valid  in  W  per-point toggle-hit strobes, sampled every cycle.
REQ-007 clear  in  1  clears the live bitmap and hit_count.
REQ-008 dump_req  in  1  requests a snapshot dump; level, sampled only in IDLE.
REQ-009 dump_ready  in  1  consumer accepts the current dump beat.
REQ-010 dump_valid  out  1  dump beat present.
REQ-011 dump_index  out  64  global index (COVER_INDEX+i) of a covered point.
REQ-012 dump_last  out  1  current beat is the final set bit of the snapshot.
REQ-013 dump_done  out  1  one-cycle pulse at dump completion.
REQ-014 dump_busy  out  1  high while state != IDLE.
REQ-015 new_hit  out  1  registered pulse: at least one previously uncovered point was hit.
REQ-016 hit_count  out  CW  number of distinct points covered since reset/clear.

Function
REQ-017 Live bitmap bm[W-1:0] is sticky: each cycle bm <= bm | valid.
REQ-018 hit_count <= hit_count + popcount(valid & ~bm); never exceeds W.
REQ-019 new_hit <= |(valid & ~bm); one cycle after the hitting cycle.
REQ-020 clear has priority over accumulation: bm <= valid, hit_count <= popcount(valid), new_hit <= |valid.
REQ-021 Accumulation and clear operate in every state; dumps never stall capture.
REQ-022 FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-023 IDLE & dump_req: snap <= bm | valid (the current cycle's hits are included), ptr <= 0, go SCAN.
REQ-024 SCAN, snap[ptr]==0: advance ptr in one cycle, no beat.
REQ-025 SCAN, snap[ptr]==1: dump_valid=1, dump_index=COVER_INDEX+ptr; beat and ptr held until dump_ready.
REQ-026 dump_index, dump_last stable while dump_valid && !dump_ready.
REQ-027 dump_last = dump_valid && (snap bits above ptr all zero).
REQ-028 Exit SCAN to DONE when ptr==W-1 and bit either clear or accepted; DONE asserts dump_done one cycle, returns to IDLE.
REQ-029 Empty snapshot: zero beats, W scan cycles, then dump_done.
REQ-030 dump_req outside IDLE ignored; a held dump_req restarts a dump on the cycle after DONE.
REQ-031 clear during SCAN modifies bm only; snap unchanged.
REQ-032 Dump latency: first beat no earlier than 1 cycle after acceptance; total <= W + beats + 1 cycles with dump_ready held high.

Reset
REQ-033 Reset asserted: bm, snap, ptr, hit_count=0; new_hit, dump_valid, dump_last, dump_done, dump_busy=0; state IDLE.
REQ-034 Reset mid-dump aborts without dump_done; next dump_req starts fresh.

Verification (W=11, COVER_INDEX=100)
REQ-035 valid=0x005 one cycle, then 0x004 -> hit_count 2, new_hit pulses once, second hit no pulse.
REQ-036 bm=0x405, dump_req, dump_ready=1 -> beats 100, 102, 110; dump_last only on 110; dump_done once.
REQ-037 Same dump with dump_ready low 3 cycles on first beat -> index 100 held stable, no beat lost or repeated.
REQ-038 Empty bitmap, dump_req -> no dump_valid, dump_done after 11 scan cycles.
REQ-039 clear with valid=0x003 same cycle -> hit_count 2, bm 0x003, new_hit 1.
REQ-040 Reset asserted during SCAN after first beat -> all outputs 0 asynchronously, no dump_done; new dump_req replays correct snapshot.
